// File: rtl/instr_encoder.sv
// Instruction encoder: packs request fields into 16-bit words and streams them to memory.
// Define INSTR_ENCODER_BEQZ_EN to encode BEQZ; otherwise op=11 is an illegal request.
module instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [2:0]  rs,
    input  logic [2:0]  rt,
    input  logic [2:0]  rd,
    input  logic [7:0]  imm,
    input  logic        mem_ready,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data,
    output logic        done,
    output logic        err
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [15:0]   fifo [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    logic        full, empty;
    logic        accept, push, pop;
    logic        legal;
    logic [15:0] word;

    always_comb begin
        word  = 16'h0000;
        legal = 1'b0;
        unique case (op)
            2'b00: legal = 1'b1;
            2'b01: begin
                word  = {5'b01000, rs, rd, imm[4:0]};
                legal = (imm[7:5] == {3{imm[4]}});
            end
            2'b10: begin
                word  = {5'b11011, rs, rt, rd, 2'b10};
                legal = 1'b1;
            end
            2'b11: begin
`ifdef INSTR_ENCODER_BEQZ_EN
                word  = {5'b01100, rs, imm};
                legal = 1'b1;
`else
                word  = 16'h0000;
                legal = 1'b0;
`endif
            end
        endcase
    end

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign in_ready = (state == RUN) && !full;
    assign mem_wr   = !empty && (state != DONE);
    assign mem_data = fifo[rd_ptr];
    assign done     = (state == DONE);

    assign accept = in_valid && in_ready;
    assign push   = accept && legal;
    assign pop    = mem_wr && mem_ready;

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr <= BASE_ADDR;
            err      <= 1'b0;
            state    <= RUN;
        end else begin
            if (pop) begin
                mem_addr <= mem_addr + 16'd2;
            end
            if (accept && !legal) begin
                err <= 1'b1;
            end
            state <= state_nxt;
        end
    end

    // Nothing is pushed after HALT, so the last pop in DRAIN is the HALT word.
    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (accept && (op == 2'b00)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && (count == ONE_CNT)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = RUN;
        endcase
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, output FIFO depth in words, power of 2, at least 2.
REQ-002 SHALL have parameter BASE_ADDR, default 16'h0000, first instruction-memory address written.
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  in  1  request fields valid.
REQ-006 SHALL have port in_ready  out  1  encoder can accept a request.
REQ-007 SHALL have port op  in  2  operation code: 00 HALT, 01 ADDI, 10 XOR, 11 BEQZ.
REQ-008 SHALL have port rs  in  3  source register 1.
REQ-009 SHALL have port rt  in  3  source register 2 (XOR only).
REQ-010 SHALL have port rd  in  3  destination register (ADDI, XOR).
REQ-011 SHALL have port imm  in  8  signed immediate (ADDI uses low 5 bits, BEQZ uses 8 bits).
REQ-012 SHALL have port mem_ready  in  1  instruction memory accepts a write this cycle.
REQ-013 SHALL have port mem_wr  out  1  memory write strobe.
REQ-014 SHALL have port mem_addr  out  16  write address.
REQ-015 SHALL have port mem_data  out  16  encoded instruction word.
REQ-016 SHALL have port done  out  1  HALT written, program complete.
REQ-017 SHALL have port err  out  1  sticky illegal-request flag.

Function
REQ-018 SHALL accept a request on a rising edge where in_valid and in_ready are both high.
REQ-019 SHALL encode HALT as 16'h0000.
REQ-020 SHALL encode ADDI as {5'b01000, rs, rd, imm[4:0]}.
REQ-021 SHALL encode XOR as {5'b11011, rs, rt, rd, 2'b10}.
REQ-022 SHALL encode BEQZ as {5'b01100, rs, imm[7:0]}.
REQ-023 SHALL flag ADDI as illegal when imm[7:5] is not all equal to imm[4], i.e. the immediate does not fit 5-bit signed.
REQ-024 SHALL consume an illegal request (handshake completes), set err, and not push any word.
REQ-025 SHALL push each legal encoded word into the FIFO on the accept edge.
REQ-026 SHALL drive in_ready = (state==RUN) && !full; push is not allowed while full, even when a pop happens in the same cycle.
REQ-027 SHALL drive mem_wr high while the FIFO is non-empty and state is not DONE; mem_data is the FIFO head.
REQ-028 SHALL pop the FIFO and advance mem_addr by 2 on each edge with mem_wr && mem_ready; mem_addr wraps 16'hFFFE to 16'h0000.
REQ-029 SHALL provide minimum latency of one cycle: a word accepted at edge N is presented on mem_wr after edge N.
REQ-030 SHALL support simultaneous push and pop when not full, leaving the count unchanged.
REQ-031 SHALL implement FSM states RUN, DRAIN, DONE.
REQ-032 SHALL transition RUN->DRAIN on acceptance of HALT; the HALT word itself is pushed.
REQ-033 SHALL transition DRAIN->DONE on the edge that pops the last word (HALT).
REQ-034 SHALL keep DONE until reset; done=1 only in DONE, and in_ready=0 in DRAIN and DONE.
REQ-035 SHALL ignore in_valid outside RUN.

Reset
REQ-036 SHALL, on rst low and asynchronously, set state=RUN, empty the FIFO, mem_addr=BASE_ADDR, mem_wr=0, done=0, err=0, with in_ready=1 after release.
REQ-037 SHALL discard any queued words when reset is asserted mid-operation, with no further memory writes until new requests arrive.

Configuration
REQ-038 SHALL, with macro INSTR_ENCODER_BEQZ_EN defined, encode op=11 per REQ-022.
REQ-039 SHALL, without INSTR_ENCODER_BEQZ_EN, treat op=11 as illegal per REQ-024; all other behaviour is identical.

Verification
REQ-040 SHALL cover: ADDI rs=1, rd=2, imm=8'h03 then HALT -> writes 16'h4143 at addr 0, then 16'h0000 at addr 2; done=1 after the second write.
REQ-041 SHALL cover: XOR rs=3, rt=4, rd=5 -> mem_data 16'hDB96.
REQ-042 SHALL cover: BEQZ rs=2, imm=8'hFC with macro -> 16'h62FC; without macro -> err=1 and no write.
REQ-043 SHALL cover: ADDI imm=8'h10 -> err=1, in_ready stays 1, no write, and later legal requests still encode.
REQ-044 SHALL cover: mem_ready=0 while pushing 5 requests -> in_ready=0 after 4; releasing mem_ready drains in order at addrs 0,2,4,6.
REQ-045 SHALL cover: rst low with 3 words queued -> mem_wr=0 immediately, mem_addr=BASE_ADDR, err=0, done=0.
